// File: rtl/gbe_tx_arb.sv
// Round-robin arbiter that merges NPORTS framed byte streams onto one TX application
// interface, truncating frames longer than MAX_BYTES and draining their remainder.
//
// state | meaning
// IDLE  | no grant held; picks the next requester round-robin when allowed
// SEND  | forwarding bytes of port g to the TX interface
// DRAIN | frame was truncated; swallowing port g's bytes up to its eof
module gbe_tx_arb #(
  parameter int NPORTS    = 4,
  parameter int MAX_BYTES = 1472
) (
  input  logic                 app_clk,
  input  logic                 app_rst_n,
  input  logic                 arb_enable,
  input  logic [NPORTS-1:0]    src_valid,
  input  logic [8*NPORTS-1:0]  src_data,
  input  logic [NPORTS-1:0]    src_eof,
  input  logic [32*NPORTS-1:0] src_destip,
  input  logic [16*NPORTS-1:0] src_destport,
  output logic [NPORTS-1:0]    src_ready,
  output logic [7:0]           app_data,
  output logic                 app_dvld,
  output logic                 app_eof,
  output logic [31:0]          app_destip,
  output logic [15:0]          app_destport,
  input  logic                 app_afull,
  input  logic                 app_overflow,
  output logic [2:0]           grant_port,
  output logic [31:0]          frames_sent,
  output logic [15:0]          trunc_count
);

  typedef enum logic [1:0] {IDLE, SEND, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [2:0]  g_q, last_g_q;
  logic [15:0] byte_cnt_q;

  logic        hi_vld, lo_vld, pick_vld;
  logic [2:0]  hi_pick, lo_pick, pick;
  logic [31:0] pick_ip;
  logic [15:0] pick_port;
  logic        sel_valid, sel_eof;
  logic [7:0]  sel_data;
  logic        can_grant, accept, at_max;

  // Round-robin: first requester above last_g, else the lowest-numbered requester.
  always_comb begin
    hi_vld  = 1'b0;
    lo_vld  = 1'b0;
    hi_pick = '0;
    lo_pick = '0;
    for (int j = 0; j < NPORTS; j++) begin
      if (src_valid[j] && (3'(j) > last_g_q) && !hi_vld) begin
        hi_vld  = 1'b1;
        hi_pick = 3'(j);
      end
      if (src_valid[j] && !lo_vld) begin
        lo_vld  = 1'b1;
        lo_pick = 3'(j);
      end
    end
    pick     = hi_vld ? hi_pick : lo_pick;
    pick_vld = hi_vld | lo_vld;
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_eof   = 1'b0;
    sel_data  = '0;
    pick_ip   = '0;
    pick_port = '0;
    for (int j = 0; j < NPORTS; j++) begin
      if (g_q == 3'(j)) begin
        sel_valid = src_valid[j];
        sel_eof   = src_eof[j];
        sel_data  = src_data[8*j +: 8];
      end
      if (pick == 3'(j)) begin
        pick_ip   = src_destip[32*j +: 32];
        pick_port = src_destport[16*j +: 16];
      end
    end
  end

  assign can_grant = (state_q == IDLE) && arb_enable && !app_afull && !app_overflow && pick_vld;
  assign accept    = sel_valid && (((state_q == SEND) && !app_afull) || (state_q == DRAIN));
  assign at_max    = (byte_cnt_q == 16'(MAX_BYTES - 1));

  always_ff @(posedge app_clk) begin
    if (!app_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    src_ready = '0;
    case (state_q)
      IDLE: begin
        if (can_grant) state_d = SEND;
      end
      SEND: begin
        for (int j = 0; j < NPORTS; j++)
          if (g_q == 3'(j)) src_ready[j] = !app_afull;
        if (accept && sel_eof)     state_d = IDLE;
        else if (accept && at_max) state_d = DRAIN;
      end
      DRAIN: begin
        for (int j = 0; j < NPORTS; j++)
          src_ready[j] = (g_q == 3'(j));
        if (accept && sel_eof) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge app_clk) begin
    if (!app_rst_n) begin
      g_q          <= '0;
      last_g_q     <= 3'(NPORTS - 1);
      byte_cnt_q   <= '0;
      app_data     <= '0;
      app_dvld     <= 1'b0;
      app_eof      <= 1'b0;
      app_destip   <= '0;
      app_destport <= '0;
      frames_sent  <= '0;
      trunc_count  <= '0;
    end else begin
      app_dvld <= 1'b0;
      app_eof  <= 1'b0;
      if (can_grant) begin
        g_q          <= pick;
        app_destip   <= pick_ip;
        app_destport <= pick_port;
        byte_cnt_q   <= '0;
      end
      if ((state_q == SEND) && accept) begin
        app_data   <= sel_data;
        app_dvld   <= 1'b1;
        app_eof    <= sel_eof | at_max;
        byte_cnt_q <= byte_cnt_q + 16'd1;
        if (sel_eof | at_max) frames_sent <= frames_sent + 32'd1;
        if (!sel_eof && at_max && (trunc_count != 16'hFFFF)) trunc_count <= trunc_count + 16'd1;
        if (sel_eof) last_g_q <= g_q;
      end
      if ((state_q == DRAIN) && accept && sel_eof) last_g_q <= g_q;
    end
  end

  assign grant_port = g_q;

endmodule

// File: tb/tb_gbe_tx_arb.sv
// Bench for gbe_tx_arb: per-port frame queues feed the DUT, and a frame-level model
// (grant order x truncation at MAX_BYTES) predicts every output beat and counter.
module tb_gbe_tx_arb;
  localparam int NP = 4;
  localparam int MB = 8;

  logic             app_clk = 1'b0;
  logic             app_rst_n, arb_enable, app_afull, app_overflow;
  logic [NP-1:0]    src_valid, src_eof, src_ready;
  logic [8*NP-1:0]  src_data;
  logic [32*NP-1:0] src_destip;
  logic [16*NP-1:0] src_destport;
  logic [7:0]       app_data;
  logic             app_dvld, app_eof;
  logic [31:0]      app_destip, frames_sent;
  logic [15:0]      app_destport, trunc_count;
  logic [2:0]       grant_port;

  always #5 app_clk = ~app_clk;

  gbe_tx_arb #(.NPORTS(NP), .MAX_BYTES(MB)) dut (
    .app_clk(app_clk), .app_rst_n(app_rst_n), .arb_enable(arb_enable),
    .src_valid(src_valid), .src_data(src_data), .src_eof(src_eof),
    .src_destip(src_destip), .src_destport(src_destport), .src_ready(src_ready),
    .app_data(app_data), .app_dvld(app_dvld), .app_eof(app_eof),
    .app_destip(app_destip), .app_destport(app_destport),
    .app_afull(app_afull), .app_overflow(app_overflow),
    .grant_port(grant_port), .frames_sent(frames_sent), .trunc_count(trunc_count)
  );

  typedef struct packed {
    logic [2:0]  port;
    logic [31:0] ip;
    logic [15:0] dp;
    logic        eof;
    logic [7:0]  d;
  } beat_t;

  beat_t         pq[NP][$];
  beat_t         exp_q[$];
  bit            mid[NP];
  bit            rand_afull = 1'b0, rand_gap = 1'b0;
  logic [NP-1:0] acc, rdy_snap;
  int ncmp = 0, nerr = 0, cyc = 0;
  int dvld_cnt = 0, first_dvld_cyc = -1, load_cyc = 0;
  int exp_frames = 0, exp_trunc = 0;
  int mark_dvld, mark_frames, n;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int p = 0; p < NP; p++) s += pq[p].size();
    return s;
  endfunction

  task automatic drive_src();
    for (int p = 0; p < NP; p++) begin
      if (pq[p].size() > 0 && !(rand_gap && mid[p] && $urandom_range(0, 3) == 0)) begin
        src_valid[p]           = 1'b1;
        src_eof[p]             = pq[p][0].eof;
        src_data[8*p +: 8]     = pq[p][0].d;
        src_destip[32*p +: 32] = pq[p][0].ip;
        src_destport[16*p +: 16] = pq[p][0].dp;
      end else begin
        src_valid[p] = 1'b0;
        src_eof[p]   = 1'b0;
      end
    end
  endtask

  task automatic tick();
    beat_t ob, e;
    @(negedge app_clk);
    acc      = src_valid & src_ready;
    rdy_snap = src_ready;
    @(posedge app_clk);
    #1;
    cyc++;
    for (int p = 0; p < NP; p++)
      if (acc[p] && pq[p].size() > 0) begin
        mid[p] = !pq[p][0].eof;
        void'(pq[p].pop_front());
      end
    if (app_dvld === 1'b1) begin
      dvld_cnt++;
      if (first_dvld_cyc < 0) first_dvld_cyc = cyc;
      if (exp_q.size() == 0) chk("unexpected_beat", 64'(app_dvld), 64'd0);
      else begin
        ob.port = grant_port; ob.ip = app_destip; ob.dp = app_destport;
        ob.eof = app_eof; ob.d = app_data;
        e = exp_q.pop_front();
        chk($sformatf("beat_port%0d", e.port), 64'(ob), 64'(e));
      end
    end
    if (rand_afull) app_afull = ($urandom_range(0, 3) == 0);
    drive_src();
  endtask

  // Source gets every byte; the TX side sees at most MB bytes with eof on the last one kept.
  task automatic add_frame(input int p, input int len, input logic [31:0] ip,
                           input logic [15:0] dp, input logic [7:0] base);
    beat_t b;
    int keep;
    keep = (len > MB) ? MB : len;
    for (int i = 0; i < len; i++) begin
      b.port = 3'(p); b.ip = ip; b.dp = dp; b.eof = (i == len - 1); b.d = base + 8'(i);
      pq[p].push_back(b);
      if (i < keep) begin
        b.eof = (i == keep - 1);
        exp_q.push_back(b);
      end
    end
    exp_frames++;
    if (len > MB) exp_trunc++;
    drive_src();
  endtask

  task automatic run(input int budget, input string tag);
    int k = 0;
    while ((exp_q.size() > 0 || pending() > 0) && k < budget) begin
      tick();
      k++;
    end
    repeat (2) tick();
    chk({tag, "_left"}, 64'(exp_q.size() + pending()), 64'd0);
  endtask

  task automatic do_reset();
    app_rst_n = 1'b0;
    tick();
    for (int p = 0; p < NP; p++) begin
      pq[p].delete();
      mid[p] = 1'b0;
    end
    exp_q.delete();
    exp_frames = 0;
    exp_trunc  = 0;
    drive_src();
    #1;
    chk("rst_ready", 64'(src_ready), 64'd0);
    chk("rst_dvld",  64'(app_dvld), 64'd0);
    chk("rst_eof",   64'(app_eof), 64'd0);
    chk("rst_data",  64'(app_data), 64'd0);
    chk("rst_ip",    64'(app_destip), 64'd0);
    chk("rst_dport", 64'(app_destport), 64'd0);
    chk("rst_grant", 64'(grant_port), 64'd0);
    chk("rst_frames", 64'(frames_sent), 64'd0);
    chk("rst_trunc", 64'(trunc_count), 64'd0);
    app_rst_n = 1'b1;
  endtask

  initial begin
    app_rst_n = 1'b0; arb_enable = 1'b1; app_afull = 1'b0; app_overflow = 1'b0;
    src_valid = '0; src_eof = '0; src_data = '0; src_destip = '0; src_destport = '0;
    tick();
    do_reset();

    // Single 4-byte frame from port 1
    first_dvld_cyc = -1;
    load_cyc = cyc;
    mark_dvld = dvld_cnt;
    add_frame(1, 4, 32'h0A000002, 16'd7148, 8'h11);
    run(50, "single");
    chk("single_latency", 64'(first_dvld_cyc - load_cyc), 64'd2);
    chk("single_beats", 64'(dvld_cnt - mark_dvld), 64'd4);
    chk("single_frames", 64'(frames_sent), 64'd1);

    // All ports offering 2-byte frames: grants 0,1,2,3,0,...
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++)
        add_frame(p, 2, 32'hC0A80000 + 32'(p), 16'(1000 + p), 8'(16 * p + 4 * r));
    run(200, "rr");
    chk("rr_frames", 64'(frames_sent), 64'(exp_frames));

    // Back-pressure mid-frame
    add_frame(2, 6, 32'h0A0000FE, 16'd53, 8'hA0);
    tick();
    chk("afull_idle_ready", 64'(rdy_snap), 64'd0);
    tick();
    tick();
    chk("afull_open_ready", 64'(rdy_snap), 64'b0100);
    app_afull = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("afull_blocked_%0d", i), 64'(rdy_snap), 64'd0);
    end
    app_afull = 1'b0;
    run(50, "afull");

    // Truncation at MB bytes, drain, then grant passes to port 3 before port 0
    add_frame(2, 12, 32'h0A000003, 16'd9000, 8'h30);
    repeat (3) tick();
    add_frame(3, 2, 32'h0A000004, 16'd9001, 8'h50);
    add_frame(0, 2, 32'h0A000005, 16'd9002, 8'h60);
    run(100, "trunc");
    chk("trunc_count", 64'(trunc_count), 64'd1);
    chk("trunc_frames", 64'(frames_sent), 64'(exp_frames));

    // Overflow blocks new grants but not the frame in flight
    mark_dvld = dvld_cnt;
    add_frame(1, 6, 32'h0A000006, 16'd4000, 8'h70);
    n = 0;
    while (dvld_cnt == mark_dvld && n < 20) begin tick(); n++; end
    app_overflow = 1'b1;
    add_frame(0, 3, 32'h0A000007, 16'd4001, 8'h80);
    n = 0;
    while (exp_q.size() > 3 && n < 40) begin tick(); n++; end
    chk("ovf_inflight_done", 64'(exp_q.size()), 64'd3);
    mark_dvld = dvld_cnt;
    mark_frames = frames_sent;
    repeat (10) tick();
    chk("ovf_no_beats", 64'(dvld_cnt - mark_dvld), 64'd0);
    chk("ovf_no_ready", 64'(rdy_snap), 64'd0);
    chk("ovf_frames_held", 64'(frames_sent), 64'(mark_frames));
    app_overflow = 1'b0;
    run(50, "ovf");
    chk("ovf_frames", 64'(frames_sent), 64'(exp_frames));

    // Reset mid-frame, then port 0 wins over port 3
    mark_dvld = dvld_cnt;
    add_frame(2, 6, 32'h0A000008, 16'd5000, 8'h90);
    n = 0;
    while (dvld_cnt < mark_dvld + 2 && n < 20) begin tick(); n++; end
    do_reset();
    add_frame(0, 2, 32'h0A000009, 16'd5001, 8'hB0);
    add_frame(3, 2, 32'h0A00000A, 16'd5002, 8'hC0);
    run(50, "post_rst");
    chk("post_rst_frames", 64'(frames_sent), 64'd2);

    // Randomised frames on all ports with random back-pressure and mid-frame gaps
    do_reset();
    rand_afull = 1'b1;
    rand_gap   = 1'b1;
    for (int r = 0; r < 6; r++)
      for (int p = 0; p < NP; p++)
        add_frame(p, $urandom_range(1, 11), $urandom, 16'($urandom), 8'($urandom));
    run(3000, "rand");
    rand_afull = 1'b0;
    rand_gap   = 1'b0;
    app_afull  = 1'b0;
    chk("rand_frames", 64'(frames_sent), 64'(exp_frames));
    chk("rand_trunc", 64'(trunc_count), 64'(exp_trunc));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/gbe_tx_arb.md
GBE_TX_ARB -- requirements
Module: gbe_tx_arb

Interface
REQ-001 Parameter NPORTS, default 4, SHALL set the number of framed byte-stream requesters (2..8).
REQ-002 Parameter MAX_BYTES, default 1472, SHALL set the maximum payload bytes per frame.
REQ-003 Ports SHALL be as follows:
- app_clk  in  1  sole clock.
- app_rst_n  in  1  synchronous active-low reset.
- arb_enable  in  1  permits new grants.
- src_valid  in  NPORTS  per-port byte valid.
- src_data  in  8*NPORTS  per-port byte; port i at [8i+7:8i].
- src_eof  in  NPORTS  per-port last byte of frame.
- src_destip  in  32*NPORTS  per-port destination IP.
- src_destport  in  16*NPORTS  per-port destination UDP port.
- src_ready  out  NPORTS  per-port byte accepted when valid & ready.
- app_data  out  8  byte to the TX application interface.
- app_dvld  out  1  byte valid.
- app_eof  out  1  last byte of frame.
- app_destip  out  32  frame destination IP.
- app_destport  out  16  frame destination port.
- app_afull  in  1  TX almost-full.
- app_overflow  in  1  TX sticky overflow.
- grant_port  out  3  index of the current or last granted port.
- frames_sent  out  32  completed frames.
- trunc_count  out  16  truncated frames.
REQ-004 The clocking SHALL be one clock, app_clk; the reset SHALL be app_rst_n, synchronous and active-low.

Function
REQ-005 The FSM SHALL have three states, IDLE, SEND and DRAIN, and SHALL hold one granted port g.
REQ-006 In IDLE with arb_enable=1, app_afull=0, app_overflow=0 and any src_valid set, the block SHALL choose g round-robin, searching from (last_g+1) mod NPORTS.
- On that choice it SHALL latch app_destip and app_destport from port g, set grant_port=g, and enter SEND on the next cycle.
REQ-007 In SEND, src_ready[g] SHALL equal !app_afull; all other src_ready bits SHALL be 0; src_ready SHALL be 0 in IDLE.
REQ-008 Each accepted byte SHALL appear on app_data with app_dvld=1 exactly one cycle later; app_dvld SHALL be 0 in every other cycle.
REQ-009 app_destip and app_destport SHALL stay constant from grant until the cycle after the frame's app_eof.
REQ-010 An accepted byte with src_eof[g]=1 SHALL produce app_eof=1 on its output cycle, return the FSM to IDLE, set last_g=g and increment frames_sent.
REQ-011 A 16-bit byte counter SHALL clear at grant and increment on each accepted byte.
- If the accepted byte is number MAX_BYTES (count==MAX_BYTES-1) and src_eof[g]=0, that byte SHALL be output with app_eof=1.
- In that case trunc_count SHALL increment, frames_sent SHALL increment, and the FSM SHALL enter DRAIN.
REQ-012 In DRAIN, src_ready[g] SHALL be 1 regardless of app_afull, and accepted bytes SHALL be discarded (app_dvld=0).
- When a byte with src_eof[g]=1 is accepted in DRAIN, the FSM SHALL go to IDLE and set last_g=g.
REQ-013 An eof on byte MAX_BYTES exactly SHALL be a normal frame: no truncation and no DRAIN.
REQ-014 Deasserting arb_enable, or asserting app_overflow, during SEND or DRAIN SHALL NOT abort the frame; it SHALL only block the next grant.
REQ-015 A port dropping src_valid mid-frame SHALL keep its grant; there SHALL be no timeout.
REQ-016 frames_sent SHALL wrap modulo 2^32; trunc_count SHALL saturate at 16'hFFFF.
REQ-017 A 1-byte frame (eof on the first byte) SHALL be legal: IDLE to SEND to IDLE.
- The minimum inter-frame spacing SHALL be one IDLE cycle.

Reset
REQ-018 While app_rst_n=0 at a clock edge, the following SHALL occur on the next cycle:
- FSM goes to IDLE; last_g=NPORTS-1, so port 0 wins first.
- src_ready=0, app_dvld=0, app_eof=0, app_data=0, app_destip=0, app_destport=0.
- grant_port=0, frames_sent=0, trunc_count=0.
REQ-019 Reset asserted mid-frame SHALL abandon the frame with no app_eof issued; the bench SHALL treat the downstream TX as reset too.

Verification
REQ-020 Port 1 alone sends a 4-byte frame 0x11..0x14 to IP 0x0A000002, port 7148 -> app_dvld high for 4 cycles, starting 2 cycles after src_valid rises; app_eof on 0x14; app_destip=0x0A000002; frames_sent=1.
REQ-021 All 4 ports continuously offer 2-byte frames -> grants follow the order 0,1,2,3,0; no output frame interleaves bytes from two ports.
REQ-022 app_afull held high for 5 cycles mid-frame -> src_ready[g]=0 for those cycles; the output byte sequence is gap-tolerant and the byte content is unchanged.
REQ-023 MAX_BYTES=8 and port 2 sends a 12-byte frame -> 8 bytes are output with app_eof on byte 8; 4 bytes are drained; trunc_count=1; the next grant goes to port 3.
REQ-024 app_overflow=1 while ports are requesting -> no grant occurs and app_dvld stays 0; a frame already in progress completes.
REQ-025 app_rst_n=0 on byte 3 of a frame -> all outputs and counters read 0 the next cycle; after release, port 0 is granted first.
